// File: rtl/sprite_draw_scheduler.sv
// sprite_draw_scheduler
//   Time-shares the single vga_adapter plot port among NUM_SLOTS sprite pixel
//   engines. On each frame_tick, slots are walked in ascending order. Each slot
//   is erased at its old position, receives a move strobe, and is then redrawn
//   at its new position. Slot NUM_SLOTS-1 is the hunter.
//
// Ports
//   clock, resetn      : system clock, async active-low reset
//   frame_tick         : one-cycle pulse that starts a redraw pass
//   slot_en            : per-slot draw enable (a disabled slot is erased only)
//   slot_colour        : per-slot draw colour, 3 bits per slot
//   eng_x/eng_y        : per-engine pixel coordinates
//   eng_valid/eng_done : per-engine pixel valid / sprite finished
//   eng_start          : one-hot start pulse to the selected engine
//   eng_erase          : engine should use its old position (erase pass)
//   move               : one-hot pulse telling an engine to advance
//   x, y, colour, plot : registered pixel port to vga_adapter
//   busy               : a pass is in progress
//   frame_overrun      : sticky, a frame_tick was dropped because we were busy
//   timeout_err        : sticky, an engine never reported done
module sprite_draw_scheduler #(
  parameter int         NUM_SLOTS = 7,
  parameter int         SCREEN_W  = 160,
  parameter int         SCREEN_H  = 120,
  parameter logic [2:0] BG_COLOUR = 3'b000,
  parameter int         TIMEOUT   = 255
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   frame_tick,
  input  logic [NUM_SLOTS-1:0]   slot_en,
  input  logic [3*NUM_SLOTS-1:0] slot_colour,
  input  logic [8*NUM_SLOTS-1:0] eng_x,
  input  logic [7*NUM_SLOTS-1:0] eng_y,
  input  logic [NUM_SLOTS-1:0]   eng_valid,
  input  logic [NUM_SLOTS-1:0]   eng_done,
  output logic [NUM_SLOTS-1:0]   eng_start,
  output logic                   eng_erase,
  output logic [NUM_SLOTS-1:0]   move,
  output logic [7:0]             x,
  output logic [6:0]             y,
  output logic [2:0]             colour,
  output logic                   plot,
  output logic                   busy,
  output logic                   frame_overrun,
  output logic                   timeout_err
);

  localparam int SLW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int TW  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [SLW-1:0] LAST_SLOT = SLW'(NUM_SLOTS - 1);
  // The WAIT cycle in which timer reaches this value is the TIMEOUT-th cycle
  // spent waiting; without done in that cycle the slot is abandoned.
  localparam logic [TW-1:0]  T_LAST    = TW'(TIMEOUT - 1);
  localparam logic [7:0]     X_LIM     = 8'(SCREEN_W);
  localparam logic [6:0]     Y_LIM     = 7'(SCREEN_H);

  typedef enum logic [2:0] {
    IDLE, E_START, E_WAIT, MOVE, D_START, D_WAIT, NEXT
  } state_t;

  state_t         state, state_n;
  logic [SLW-1:0] slot;
  logic [TW-1:0]  timer;

  // Unpacked views of the flat per-slot buses.
  logic [NUM_SLOTS-1:0][7:0] ex;
  logic [NUM_SLOTS-1:0][6:0] ey;
  logic [NUM_SLOTS-1:0][2:0] sc;
  assign ex = eng_x;
  assign ey = eng_y;
  assign sc = slot_colour;

  logic       in_wait, done_sel, timeout_hit, on_screen;
  logic [7:0] sel_x;
  logic [6:0] sel_y;

  assign in_wait   = (state == E_WAIT) || (state == D_WAIT);
  assign done_sel  = eng_done[slot];
  assign sel_x     = ex[slot];
  assign sel_y     = ey[slot];
  // Engines may wrap coordinates (e.g. 8'hFF); those are simply never plotted.
  assign on_screen = (sel_x < X_LIM) && (sel_y < Y_LIM);
  assign busy      = (state != IDLE);

  always_comb begin
    state_n     = state;
    eng_start   = '0;
    move        = '0;
    eng_erase   = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE:    if (frame_tick) state_n = E_START;
      E_START: begin
        eng_start[slot] = 1'b1;
        eng_erase       = 1'b1;
        state_n         = E_WAIT;
      end
      E_WAIT: begin
        eng_erase = 1'b1;
        // slot_en is looked at only here, so mid-pass changes affect later slots.
        if (done_sel)             state_n = slot_en[slot] ? MOVE : NEXT;
        else if (timer == T_LAST) begin
          timeout_hit = 1'b1;
          state_n     = NEXT;
        end
      end
      MOVE: begin
        move[slot] = 1'b1;
        state_n    = D_START;
      end
      D_START: begin
        eng_start[slot] = 1'b1;
        state_n         = D_WAIT;
      end
      D_WAIT: begin
        if (done_sel)             state_n = NEXT;
        else if (timer == T_LAST) begin
          timeout_hit = 1'b1;
          state_n     = NEXT;
        end
      end
      NEXT:    state_n = (slot == LAST_SLOT) ? IDLE : E_START;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      slot          <= '0;
      timer         <= '0;
      x             <= '0;
      y             <= '0;
      colour        <= '0;
      plot          <= 1'b0;
      frame_overrun <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      state <= state_n;

      if (state == IDLE && frame_tick)            slot <= '0;
      else if (state == NEXT && slot != LAST_SLOT) slot <= slot + 1'b1;

      if (state == E_START || state == D_START) timer <= '0;
      else if (in_wait)                         timer <= timer + 1'b1;

      // Any tick outside IDLE is dropped, including the NEXT->IDLE cycle.
      if (frame_tick && state != IDLE) frame_overrun <= 1'b1;
      if (timeout_hit)                 timeout_err   <= 1'b1;

      // Pixel port: one-cycle registered mux; holds its last value when idle.
      plot <= in_wait && eng_valid[slot] && on_screen;
      if (in_wait) begin
        x      <= sel_x;
        y      <= sel_y;
        colour <= (state == E_WAIT) ? BG_COLOUR : sc[slot];
      end
    end
  end

endmodule

// File: tb/tb_sprite_draw_scheduler.sv
// Scoreboard bench for sprite_draw_scheduler: a per-slot engine model drives
// the engine ports, each test pushes its expected plot/move sequence, and a
// monitor pops and compares whenever the DUT plots or pulses move.
module tb_sprite_draw_scheduler;
  localparam int NS = 7;
  localparam int P  = 13;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic frame_tick = 1'b0;
  logic [NS-1:0]      slot_en = '0;
  logic [NS-1:0][2:0] slot_colour = '0;
  logic [NS-1:0][7:0] eng_x = '0;
  logic [NS-1:0][6:0] eng_y = '0;
  logic [NS-1:0]      eng_valid = '0;
  logic [NS-1:0]      eng_done = '0;
  logic [NS-1:0]      eng_start, move;
  logic               eng_erase, plot, busy, frame_overrun, timeout_err;
  logic [7:0]         x;
  logic [6:0]         y;
  logic [2:0]         colour;

  always #10 clock = ~clock;

  sprite_draw_scheduler #(.NUM_SLOTS(NS), .TIMEOUT(20)) dut (
    .clock(clock), .resetn(resetn), .frame_tick(frame_tick),
    .slot_en(slot_en), .slot_colour(slot_colour),
    .eng_x(eng_x), .eng_y(eng_y), .eng_valid(eng_valid), .eng_done(eng_done),
    .eng_start(eng_start), .eng_erase(eng_erase), .move(move),
    .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy),
    .frame_overrun(frame_overrun), .timeout_err(timeout_err)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // ---------------- engine model ----------------
  // Engine i draws P pixels in a row at (bx[i]+k, 10+i); move advances bx by 1.
  // clip[i]: emits (255,5) then (159,119). stall_erase[i]: never signals done
  // on an erase pass.
  int bx[NS];
  int idx[NS];
  bit act[NS];
  bit erm[NS];
  bit clip[NS];
  bit stall_erase[NS];

  always @(negedge clock) begin
    if (!resetn) begin
      for (int i = 0; i < NS; i++) begin
        act[i] = 0; idx[i] = 0; bx[i] = 20 * i;
      end
      eng_valid = '0;
      eng_done  = '0;
    end else begin
      for (int i = 0; i < NS; i++) begin
        eng_valid[i] = 1'b0;
        eng_done[i]  = 1'b0;
        if (move[i]) bx[i] = bx[i] + 1;
        if (act[i]) begin
          if (clip[i]) begin
            eng_x[i] = (idx[i] == 0) ? 8'hFF : 8'd159;
            eng_y[i] = (idx[i] == 0) ? 7'd5  : 7'd119;
          end else begin
            eng_x[i] = 8'(bx[i] + idx[i]);
            eng_y[i] = 7'(10 + i);
          end
          eng_valid[i] = 1'b1;
          eng_done[i]  = (idx[i] == (clip[i] ? 1 : P - 1)) && !(erm[i] && stall_erase[i]);
          idx[i]++;
          if (idx[i] == (clip[i] ? 2 : P)) act[i] = 0;
        end
        if (eng_start[i]) begin
          act[i] = 1; idx[i] = 0; erm[i] = eng_erase;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct { bit mv; int x; int y; int c; int s; } ev_t;
  ev_t sb[$];
  int  ebx[NS];

  task automatic push_plot(input int px, input int py, input int pc);
    ev_t e; e.mv = 0; e.x = px; e.y = py; e.c = pc; e.s = 0; sb.push_back(e);
  endtask

  task automatic push_move(input int s);
    ev_t e; e.mv = 1; e.x = 0; e.y = 0; e.c = 0; e.s = s; sb.push_back(e);
  endtask

  task automatic push_pixels(input int s, input int c);
    if (clip[s]) push_plot(159, 119, c);
    else for (int k = 0; k < P; k++) push_plot(ebx[s] + k, 10 + s, c);
  endtask

  task automatic push_pass();
    for (int s = 0; s < NS; s++) begin
      push_pixels(s, 0);
      if (stall_erase[s] || !slot_en[s]) continue;
      push_move(s);
      ebx[s]++;
      push_pixels(s, int'(slot_colour[s]));
    end
  endtask

  always @(negedge clock) begin
    if (resetn) begin
      if (plot) begin
        if (sb.size() == 0) chk("unexpected_plot", 1, 0);
        else begin
          ev_t e; e = sb.pop_front();
          chk("plot_kind", int'(e.mv), 0);
          chk("plot_x", int'(x), e.x);
          chk("plot_y", int'(y), e.y);
          chk("plot_colour", int'(colour), e.c);
        end
      end
      if (move != '0) begin
        chk("move_onehot", int'($onehot(move)), 1);
        if (sb.size() == 0) chk("unexpected_move", 1, 0);
        else begin
          ev_t e; e = sb.pop_front();
          chk("move_kind", int'(e.mv), 1);
          chk("move_slot", $clog2(int'(move)), e.s);
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(negedge clock) frame_tick = 1'b1;
    @(negedge clock) frame_tick = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while ((busy || sb.size() != 0) && n < 3000) begin
      @(negedge clock); n++;
    end
    chk({nm, "_finished"}, int'(n < 3000), 1);
    chk({nm, "_sb_empty"}, sb.size(), 0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NS; i++) ebx[i] = 20 * i;
    sb.delete();
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_eng_start"}, int'(eng_start), 0);
    chk({nm, "_move"}, int'(move), 0);
    chk({nm, "_x"}, int'(x), 0);
    chk({nm, "_y"}, int'(y), 0);
    chk({nm, "_colour"}, int'(colour), 0);
    chk({nm, "_plot"}, int'(plot), 0);
    chk({nm, "_eng_erase"}, int'(eng_erase), 0);
    chk({nm, "_busy"}, int'(busy), 0);
    chk({nm, "_overrun"}, int'(frame_overrun), 0);
    chk({nm, "_timeout"}, int'(timeout_err), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, seen;
    for (int i = 0; i < NS; i++) begin
      clip[i] = 0; stall_erase[i] = 0;
    end
    model_reset();
    repeat (3) @(negedge clock);
    chk_all_zero("reset");
    resetn = 1'b1;

    // Reset in the middle of slot 2's draw.
    slot_en = 7'h7F;
    slot_colour = {3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    push_pass();
    tick();
    n = 0;
    while (!move[2] && n < 2000) begin @(negedge clock); n++; end
    chk("mid_reset_reached_move2", int'(n < 2000), 1);
    @(negedge clock);            // D_START
    @(negedge clock);            // D_WAIT of slot 2
    #3 resetn = 1'b0;
    #1 chk_all_zero("async_reset");
    model_reset();
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge clock);
      if (eng_start != '0 || busy) seen++;
    end
    chk("idle_after_reset", seen, 0);

    // Single enabled slot: erase everything, move and draw slot 0 only.
    slot_en = 7'b0000001;
    slot_colour = '0;
    slot_colour[0] = 3'b111;
    push_pass();
    tick();
    chk("busy_in_pass", int'(busy), 1);
    wait_idle("single");

    // Clipping: (255,5) dropped, (159,119) plotted.
    clip[0] = 1;
    push_pass();
    tick();
    wait_idle("clip");
    clip[0] = 0;

    // All slots, hunter colour 001.
    slot_en = 7'h7F;
    slot_colour = {3'b001, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    push_pass();
    tick();
    wait_idle("hunter");

    // Overrun: second tick mid-pass is dropped and flagged.
    chk("overrun_clear", int'(frame_overrun), 0);
    slot_en = 7'b0000101;
    push_pass();
    tick();
    repeat (30) @(negedge clock);
    tick();
    chk("overrun_set", int'(frame_overrun), 1);
    wait_idle("overrun");
    seen = 0;
    repeat (50) begin
      @(negedge clock);
      if (busy || eng_start != '0) seen++;
    end
    chk("no_second_pass", seen, 0);

    // Timeout: engine 3 never finishes its erase.
    chk("timeout_clear", int'(timeout_err), 0);
    slot_en = 7'h7F;
    stall_erase[3] = 1;
    push_pass();
    tick();
    wait_idle("timeout");
    chk("timeout_set", int'(timeout_err), 1);
    chk("overrun_sticky", int'(frame_overrun), 1);
    stall_erase[3] = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
